// File: rtl/nios_mult_cell_pipe.sv
// nios_mult_cell_pipe
//   Pipelined half-word partial-product multiplier cell. Each operand is split
//   into lo/hi halves and the four half x half products are formed before the
//   first register stage, then carried down PIPE_STAGES stages along with a
//   valid bit. M_en stalls the whole pipe and M_flush kills every valid bit.
//   Optional feature macro: MULT_CELL_FULL_PRODUCT_EN adds one combine stage
//   that recombines the partial products into the full 2*DATA_W product.
module nios_mult_cell_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                E_valid,
  input  logic [DATA_W-1:0]   E_src1,
  input  logic [DATA_W-1:0]   E_src2,
  input  logic [1:0]          E_signed,
  input  logic                M_en,
  input  logic                M_flush,
  output logic                M_mul_valid,
  output logic [DATA_W-1:0]   M_mul_cell_p1,
  output logic [DATA_W-1:0]   M_mul_cell_p2,
  output logic [DATA_W-1:0]   M_mul_cell_p3,
  output logic [DATA_W-1:0]   M_mul_cell_p4
`ifdef MULT_CELL_FULL_PRODUCT_EN
 ,output logic [2*DATA_W-1:0] M_mul_full,
  output logic                M_mul_full_valid
`endif
);

  localparam int H = DATA_W / 2;

  // Halves extended to DATA_W: the low DATA_W bits of the product depend only
  // on the low DATA_W bits of the operands, and every product fits DATA_W.
  logic [DATA_W-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
  logic [DATA_W-1:0] m1, m2, m3, m4;

  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]      p1_q [PIPE_STAGES];
  logic [DATA_W-1:0]      p2_q [PIPE_STAGES];
  logic [DATA_W-1:0]      p3_q [PIPE_STAGES];
  logic [DATA_W-1:0]      p4_q [PIPE_STAGES];
  logic [DATA_W-1:0]      p1_d [PIPE_STAGES];
  logic [DATA_W-1:0]      p2_d [PIPE_STAGES];
  logic [DATA_W-1:0]      p3_d [PIPE_STAGES];
  logic [DATA_W-1:0]      p4_d [PIPE_STAGES];
`ifdef MULT_CELL_FULL_PRODUCT_EN
  logic [1:0]             sgn_q [PIPE_STAGES];
  logic [1:0]             sgn_d [PIPE_STAGES];
`endif

  // Operand split and partial-product formation ahead of stage 1
  always_comb begin
    a_lo_x = {{(DATA_W-H){1'b0}}, E_src1[H-1:0]};
    b_lo_x = {{(DATA_W-H){1'b0}}, E_src2[H-1:0]};
    a_hi_x = {{(DATA_W-H){E_signed[0] & E_src1[DATA_W-1]}}, E_src1[DATA_W-1:H]};
    b_hi_x = {{(DATA_W-H){E_signed[1] & E_src2[DATA_W-1]}}, E_src2[DATA_W-1:H]};
    m1 = a_lo_x * b_lo_x;
    m2 = a_lo_x * b_hi_x;
    m3 = a_hi_x * b_lo_x;
    m4 = a_hi_x * b_hi_x;
  end

  // Next-state: valid bits shift on enable, data loads only behind a valid op
  always_comb begin
    valid_d = valid_q;
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    p4_d = p4_q;
`ifdef MULT_CELL_FULL_PRODUCT_EN
    sgn_d = sgn_q;
`endif
    if (M_flush) begin
      valid_d = '0;
    end else if (M_en) begin
      valid_d[0] = E_valid;
      for (int s = 1; s < PIPE_STAGES; s++) valid_d[s] = valid_q[s-1];
      if (E_valid) begin
        p1_d[0] = m1;
        p2_d[0] = m2;
        p3_d[0] = m3;
        p4_d[0] = m4;
`ifdef MULT_CELL_FULL_PRODUCT_EN
        sgn_d[0] = E_signed;
`endif
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (valid_q[s-1]) begin
          p1_d[s] = p1_q[s-1];
          p2_d[s] = p2_q[s-1];
          p3_d[s] = p3_q[s-1];
          p4_d[s] = p4_q[s-1];
`ifdef MULT_CELL_FULL_PRODUCT_EN
          sgn_d[s] = sgn_q[s-1];
`endif
        end
      end
    end
  end

  // Pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        p1_q[s] <= '0;
        p2_q[s] <= '0;
        p3_q[s] <= '0;
        p4_q[s] <= '0;
`ifdef MULT_CELL_FULL_PRODUCT_EN
        sgn_q[s] <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
      p4_q <= p4_d;
`ifdef MULT_CELL_FULL_PRODUCT_EN
      sgn_q <= sgn_d;
`endif
    end
  end

  assign M_mul_valid   = valid_q[PIPE_STAGES-1];
  assign M_mul_cell_p1 = p1_q[PIPE_STAGES-1];
  assign M_mul_cell_p2 = p2_q[PIPE_STAGES-1];
  assign M_mul_cell_p3 = p3_q[PIPE_STAGES-1];
  assign M_mul_cell_p4 = p4_q[PIPE_STAGES-1];

`ifdef MULT_CELL_FULL_PRODUCT_EN
  logic [2*DATA_W-1:0] full_q, full_d, full_sum;
  logic                full_valid_q, full_valid_d;
  logic [1:0]          sgn_out;
  logic                s2, s3, s4;

  // Recombine: p2/p3 weighted by 2^H, p4 by 2^(2H); p4 is signed if either operand is
  always_comb begin
    sgn_out  = sgn_q[PIPE_STAGES-1];
    s2       = sgn_out[1] & M_mul_cell_p2[DATA_W-1];
    s3       = sgn_out[0] & M_mul_cell_p3[DATA_W-1];
    s4       = (sgn_out[0] | sgn_out[1]) & M_mul_cell_p4[DATA_W-1];
    full_sum = {{DATA_W{1'b0}}, M_mul_cell_p1}
             + ({{DATA_W{s2}}, M_mul_cell_p2} << H)
             + ({{DATA_W{s3}}, M_mul_cell_p3} << H)
             + ({{DATA_W{s4}}, M_mul_cell_p4} << (2*H));
    full_valid_d = full_valid_q;
    full_d       = full_q;
    if (M_flush) begin
      full_valid_d = 1'b0;
    end else if (M_en) begin
      full_valid_d = M_mul_valid;
      if (M_mul_valid) full_d = full_sum;
    end
  end

  // Combine-stage register, same reset/flush/stall rules as the pipe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q       <= '0;
      full_valid_q <= 1'b0;
    end else begin
      full_q       <= full_d;
      full_valid_q <= full_valid_d;
    end
  end

  assign M_mul_full       = full_q;
  assign M_mul_full_valid = full_valid_q;
`endif

endmodule
